// File: rtl/mem_wb_skid_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_skid_stage
//
// MEM/WB pipeline stage for the AdamRiscv core. A two-entry skid buffer
// (head + skid) with a valid/ready handshake on both sides, so stalls
// in writeback neither drop nor duplicate results.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   flush               synchronous kill of every buffered entry
//   me_valid/me_ready   upstream handshake (me_ready is decoded from state only)
//   me_*                upstream entry fields
//   wb_valid/wb_ready   downstream handshake, wb_* reflect the head entry
//   fwd_valid/rd/data   registered scalar forwarding view of the head entry
//   occupancy           number of buffered entries (0, 1 or 2)
// -----------------------------------------------------------------------------
module mem_wb_skid_stage #(
    parameter int XLEN = 32,
    parameter int MLEN = 128,
    parameter int RW   = 5,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            me_valid,
    output logic            me_ready,
    input  logic [XLEN-1:0] me_mem_data,
    input  logic [XLEN-1:0] me_alu_o,
    input  logic [MLEN-1:0] me_matrix_o,
    input  logic [RW-1:0]   me_rd,
    input  logic            me_mem2reg,
    input  logic [SELW-1:0] me_w_select,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_mem_data,
    output logic [XLEN-1:0] wb_alu_o,
    output logic [MLEN-1:0] wb_matrix_o,
    output logic [RW-1:0]   wb_rd,
    output logic            wb_mem2reg,
    output logic [SELW-1:0] wb_w_select,
    output logic            fwd_valid,
    output logic [RW-1:0]   fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic [1:0]      occupancy
);

    localparam int EW = 2 * XLEN + MLEN + RW + 1 + SELW;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]      r_state;
    logic [EW-1:0]   r_head;
    logic [EW-1:0]   r_skid;
    logic            r_fwd_valid;
    logic [RW-1:0]   r_fwd_rd;
    logic [XLEN-1:0] r_fwd_data;

    logic [1:0]      w_state_next;
    logic [EW-1:0]   w_head_next;
    logic [EW-1:0]   w_skid_next;
    logic [EW-1:0]   w_in;
    logic            w_accept;
    logic            w_pop;

    // Fields of the next head entry, used to precompute the forwarding port.
    logic [XLEN-1:0] w_hn_mem_data;
    logic [XLEN-1:0] w_hn_alu_o;
    logic [MLEN-1:0] w_hn_matrix_o;
    logic [RW-1:0]   w_hn_rd;
    logic            w_hn_mem2reg;
    logic [SELW-1:0] w_hn_w_select;
    logic            w_fwd_valid_next;
    logic [XLEN-1:0] w_fwd_data_next;

    assign w_in = {me_mem_data, me_alu_o, me_matrix_o, me_rd, me_mem2reg, me_w_select};

    // me_ready depends on the state register only, never on wb_ready.
    assign me_ready  = (r_state != ST_FULL);
    assign wb_valid  = (r_state != ST_EMPTY);
    assign occupancy = r_state;
    assign w_accept  = me_valid & me_ready;
    assign w_pop     = wb_valid & wb_ready;

    assign {wb_mem_data, wb_alu_o, wb_matrix_o, wb_rd, wb_mem2reg, wb_w_select} = r_head;

    assign fwd_valid = r_fwd_valid;
    assign fwd_rd    = r_fwd_rd;
    assign fwd_data  = r_fwd_data;

    // Next-state and next-entry selection for the skid buffer.
    always_comb begin
        w_state_next = r_state;
        w_head_next  = r_head;
        w_skid_next  = r_skid;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_head_next  = w_in;
                    w_state_next = ST_ONE;
                end else begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_head_next  = w_in;
                    w_state_next = ST_ONE;
                end else if (w_accept) begin
                    w_skid_next  = w_in;
                    w_state_next = ST_FULL;
                end else if (w_pop) begin
                    w_state_next = ST_EMPTY;
                end else begin
                    w_state_next = ST_ONE;
                end
            end
            ST_FULL: begin
                // The skid entry is older than anything upstream, so it
                // becomes the head; upstream is stalled by me_ready = 0.
                if (w_pop) begin
                    w_head_next  = r_skid;
                    w_state_next = ST_ONE;
                end else begin
                    w_state_next = ST_FULL;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
        // Flush only invalidates; stale data is harmless while wb_valid = 0.
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            w_state_next = w_state_next;
        end
    end

    assign {w_hn_mem_data, w_hn_alu_o, w_hn_matrix_o, w_hn_rd, w_hn_mem2reg, w_hn_w_select} = w_head_next;

    // Forwarding view of the next head, registered alongside it so that
    // fwd_* always describe the entry on wb_* with no combinational decode.
    always_comb begin
        w_fwd_valid_next = (w_state_next != ST_EMPTY) &&
                           (w_hn_rd != {RW{1'b0}}) &&
                           (w_hn_w_select != {SELW{1'b0}});
        if (w_hn_mem2reg) begin
            w_fwd_data_next = w_hn_mem_data;
        end else begin
            w_fwd_data_next = w_hn_alu_o;
        end
    end

    // State, entry and forwarding registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_EMPTY;
            r_head      <= {EW{1'b0}};
            r_skid      <= {EW{1'b0}};
            r_fwd_valid <= 1'b0;
            r_fwd_rd    <= {RW{1'b0}};
            r_fwd_data  <= {XLEN{1'b0}};
        end else begin
            r_state     <= w_state_next;
            r_head      <= w_head_next;
            r_skid      <= w_skid_next;
            r_fwd_valid <= w_fwd_valid_next;
            r_fwd_rd    <= w_hn_rd;
            r_fwd_data  <= w_fwd_data_next;
        end
    end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
module tb_mem_wb_skid_stage;

    typedef struct packed {
        logic [31:0]  mem;
        logic [31:0]  alu;
        logic [127:0] mat;
        logic [4:0]   rd;
        logic         m2r;
        logic [1:0]   ws;
    } ent_t;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         me_valid;
    logic         me_ready;
    logic         wb_valid;
    logic         wb_ready;
    logic [31:0]  wb_mem_data;
    logic [31:0]  wb_alu_o;
    logic [127:0] wb_matrix_o;
    logic [4:0]   wb_rd;
    logic         wb_mem2reg;
    logic [1:0]   wb_w_select;
    logic         fwd_valid;
    logic [4:0]   fwd_rd;
    logic [31:0]  fwd_data;
    logic [1:0]   occupancy;
    ent_t         drv;

    int n_vec;
    int n_err;

    ent_t exp_q[$];   // entries the model holds in the buffer, oldest first
    ent_t done_q[$];  // expected output order
    ent_t obs_q[$];   // what the DUT actually handed over

    mem_wb_skid_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .me_valid(me_valid), .me_ready(me_ready),
        .me_mem_data(drv.mem), .me_alu_o(drv.alu), .me_matrix_o(drv.mat),
        .me_rd(drv.rd), .me_mem2reg(drv.m2r), .me_w_select(drv.ws),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_mem_data(wb_mem_data), .wb_alu_o(wb_alu_o), .wb_matrix_o(wb_matrix_o),
        .wb_rd(wb_rd), .wb_mem2reg(wb_mem2reg), .wb_w_select(wb_w_select),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t mk(logic [31:0] alu, logic [4:0] rd, logic m2r,
                                logic [31:0] mem, logic [127:0] mat, logic [1:0] ws);
        ent_t e;
        e.alu = alu; e.rd = rd; e.m2r = m2r; e.mem = mem; e.mat = mat; e.ws = ws;
        return e;
    endfunction

    function automatic ent_t wb_obs();
        ent_t e;
        e.mem = wb_mem_data; e.alu = wb_alu_o; e.mat = wb_matrix_o;
        e.rd = wb_rd; e.m2r = wb_mem2reg; e.ws = wb_w_select;
        return e;
    endfunction

    // One clock: the model decides accept/pop from its own occupancy, records
    // the DUT head on a pop, then the edge happens and inputs may change at +1.
    task automatic tick();
        bit acc;
        bit pop;
        @(negedge clk);
        acc = me_valid && (exp_q.size() < 2);
        pop = wb_ready && (exp_q.size() > 0);
        if (pop) begin
            obs_q.push_back(wb_obs());
            done_q.push_back(exp_q.pop_front());
        end
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back(drv);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        obs_q.delete();
        done_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; wb_ready = 1'b0; me_valid = 1'b1;
        drv = mk(32'h1234_5678, 5'd7, 1'b1, 32'hCAFE_F00D, {4{32'h5555_AAAA}}, 2'd1);
        @(posedge clk); @(posedge clk); #1;
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got %0b want 0", wb_valid); end
        n_vec++; if ({wb_mem_data, wb_alu_o, wb_matrix_o, wb_rd, wb_mem2reg, wb_w_select} !== '0) begin
            n_err++; $display("FAIL reset_wb_fields got %h want 0", {wb_mem_data, wb_alu_o, wb_matrix_o, wb_rd, wb_mem2reg, wb_w_select}); end
        n_vec++; if ({fwd_valid, fwd_rd, fwd_data} !== 38'd0) begin n_err++; $display("FAIL reset_fwd got %h want 0", {fwd_valid, fwd_rd, fwd_data}); end
        n_vec++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_vec++; if (me_ready !== 1'b1) begin n_err++; $display("FAIL reset_me_ready got %0b want 1", me_ready); end
        me_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        clear_sb();
    endtask

    task automatic test_streaming();
        clear_sb();
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            me_valid = 1'b1;
            drv = mk(32'h11 * (i + 1), 5'(i + 1), 1'b0, 32'h0, 128'd0, 2'd1);
            tick();
            n_vec++; if (wb_valid !== 1'b1 || wb_alu_o !== 32'(32'h11 * (i + 1))) begin
                n_err++; $display("FAIL stream_head[%0d] got v=%0b alu=%h want v=1 alu=%h", i, wb_valid, wb_alu_o, 32'h11 * (i + 1)); end
            n_vec++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'(i + 1)) begin
                n_err++; $display("FAIL stream_fwd[%0d] got v=%0b rd=%0d want v=1 rd=%0d", i, fwd_valid, fwd_rd, i + 1); end
        end
        me_valid = 1'b0;
        tick();
        n_vec++; if (obs_q.size() !== 4) begin n_err++; $display("FAIL stream_count got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < done_q.size(); i++) begin
            n_vec++; if (obs_q[i] !== done_q[i]) begin n_err++; $display("FAIL stream_order[%0d] got %h want %h", i, obs_q[i], done_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        ent_t a;
        clear_sb();
        wb_ready = 1'b0;
        a = mk(32'hA, 5'd10, 1'b0, 32'h0, {8{16'hAAAA}}, 2'd2);
        me_valid = 1'b1;
        drv = a; tick();
        drv = mk(32'hB, 5'd11, 1'b0, 32'h0, {8{16'hBBBB}}, 2'd1); tick();
        drv = mk(32'hC, 5'd12, 1'b1, 32'hC0C0, {8{16'hCCCC}}, 2'd1); tick();
        n_vec++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occupancy got %0d want 2", occupancy); end
        n_vec++; if (me_ready !== 1'b0) begin n_err++; $display("FAIL bp_me_ready got %0b want 0", me_ready); end
        n_vec++; if (wb_matrix_o !== a.mat) begin n_err++; $display("FAIL bp_head_hold got %h want %h", wb_matrix_o, a.mat); end
        wb_ready = 1'b1;
        tick(); tick();
        me_valid = 1'b0;
        tick(); tick();
        n_vec++; if (obs_q.size() !== 3) begin n_err++; $display("FAIL bp_count got %0d want 3", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < done_q.size(); i++) begin
            n_vec++; if (obs_q[i] !== done_q[i]) begin n_err++; $display("FAIL bp_order[%0d] got %h want %h", i, obs_q[i], done_q[i]); end
        end
    endtask

    task automatic test_forward();
        clear_sb();
        wb_ready = 1'b0;
        me_valid = 1'b1;
        drv = mk(32'h5, 5'd3, 1'b1, 32'hDEAD_BEEF, 128'd0, 2'd1); tick();
        me_valid = 1'b0;
        n_vec++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd3 || fwd_data !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL fwd_load got v=%0b rd=%0d d=%h want v=1 rd=3 d=deadbeef", fwd_valid, fwd_rd, fwd_data); end
        wb_ready = 1'b1; tick(); wb_ready = 1'b0;
        me_valid = 1'b1;
        drv = mk(32'h6, 5'd0, 1'b0, 32'h0, 128'd0, 2'd1); tick();
        me_valid = 1'b0;
        n_vec++; if (fwd_valid !== 1'b0 || wb_valid !== 1'b1) begin n_err++; $display("FAIL fwd_rd0 got v=%0b wbv=%0b want v=0 wbv=1", fwd_valid, wb_valid); end
        wb_ready = 1'b1; tick(); wb_ready = 1'b0;
        me_valid = 1'b1;
        drv = mk(32'h7, 5'd9, 1'b0, 32'h0, 128'd0, 2'd0); tick();
        me_valid = 1'b0;
        n_vec++; if (fwd_valid !== 1'b0) begin n_err++; $display("FAIL fwd_wsel0 got %0b want 0", fwd_valid); end
        wb_ready = 1'b1; tick(); wb_ready = 1'b0;
        me_valid = 1'b1;
        drv = mk(32'h8765_4321, 5'd31, 1'b0, 32'h1111_2222, 128'd0, 2'd3); tick();
        me_valid = 1'b0;
        n_vec++; if (fwd_valid !== 1'b1 || fwd_data !== 32'h8765_4321 || fwd_rd !== 5'd31) begin
            n_err++; $display("FAIL fwd_alu got v=%0b rd=%0d d=%h want v=1 rd=31 d=87654321", fwd_valid, fwd_rd, fwd_data); end
        wb_ready = 1'b1; tick();
        n_vec++; if (obs_q.size() !== 4) begin n_err++; $display("FAIL fwd_count got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < done_q.size(); i++) begin
            n_vec++; if (obs_q[i] !== done_q[i]) begin n_err++; $display("FAIL fwd_order[%0d] got %h want %h", i, obs_q[i], done_q[i]); end
        end
    endtask

    task automatic test_flush();
        clear_sb();
        wb_ready = 1'b0;
        me_valid = 1'b1;
        drv = mk(32'h55, 5'd1, 1'b0, 32'h0, 128'd0, 2'd1); tick();
        drv = mk(32'h66, 5'd2, 1'b0, 32'h0, 128'd0, 2'd1); tick();
        n_vec++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ got %0d want 2", occupancy); end
        flush = 1'b1;
        drv = mk(32'h99, 5'd3, 1'b0, 32'h0, 128'd0, 2'd1); tick();
        flush = 1'b0;
        me_valid = 1'b0;
        n_vec++; if (wb_valid !== 1'b0 || occupancy !== 2'd0 || me_ready !== 1'b1 || fwd_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_state got v=%0b occ=%0d rdy=%0b fv=%0b want 0 0 1 0", wb_valid, occupancy, me_ready, fwd_valid); end
        tick();
        wb_ready = 1'b1;
        me_valid = 1'b1;
        drv = mk(32'h77, 5'd4, 1'b0, 32'h0, 128'd0, 2'd1); tick();
        me_valid = 1'b0;
        n_vec++; if (wb_valid !== 1'b1 || wb_alu_o !== 32'h77) begin n_err++; $display("FAIL flush_next got v=%0b alu=%h want v=1 alu=77", wb_valid, wb_alu_o); end
        tick();
        n_vec++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL flush_count got %0d want 1", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < done_q.size(); i++) begin
            n_vec++; if (obs_q[i] !== done_q[i]) begin n_err++; $display("FAIL flush_order[%0d] got %h want %h", i, obs_q[i], done_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        wb_ready = 1'b0;
        me_valid = 1'b1;
        drv = mk(32'h100, 5'd1, 1'b0, 32'h0, 128'd0, 2'd1); tick();
        wb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drv = mk($urandom, 5'($urandom_range(1, 31)), 1'($urandom), $urandom,
                     {$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(1, 3)));
            tick();
            n_vec++; if (occupancy !== 2'd1 || me_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_occ[%0d] got occ=%0d rdy=%0b want occ=1 rdy=1", i, occupancy, me_ready); end
            n_vec++; if (wb_obs() !== drv) begin n_err++; $display("FAIL b2b_head[%0d] got %h want %h", i, wb_obs(), drv); end
        end
        me_valid = 1'b0;
        tick();
        n_vec++; if (obs_q.size() !== 11) begin n_err++; $display("FAIL b2b_count got %0d want 11", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < done_q.size(); i++) begin
            n_vec++; if (obs_q[i] !== done_q[i]) begin n_err++; $display("FAIL b2b_order[%0d] got %h want %h", i, obs_q[i], done_q[i]); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        flush = 1'b0;
        me_valid = 1'b0;
        wb_ready = 1'b0;
        drv = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_forward();
        test_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
